bcd_entry_sequencer: RTL and testbench
======================================

Name: bcd_entry_sequencer

Overview:
- Upstream feeder for the dual 7-segment memory stage.
- Takes a raw active-low pushbutton and a 4-bit switch value, and debounces the button.
- Validates the value as BCD and issues one write strobe per press, with registered data and digit select.
- Alternates between digit A (tens) and digit B (ones) so that two presses load a two-digit number.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a press or a release (legal range 2..2^CNT_W-1)
CNT_W, 20, debounce counter width

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RESETn  input  1  synchronous active-low reset, sampled on the rising edge of CLK
KEYn  input  1  raw pushbutton, active-low, asynchronous to CLK
BCD  input  4  switch value, sampled when a press is accepted
CLR  input  1  synchronous clear of the digit pointer, active-high
DATA_OUT  output  4  registered digit to write; held until the next accepted write
SEL  output  1  registered digit target: 1 = display A, 0 = display B
WR  output  1  one-cycle write strobe
ERR  output  1  one-cycle pulse: press accepted but BCD > 9
DONE  output  1  one-cycle pulse, coincident with the WR that writes digit B

Behaviour:
- Reset (RESETn low at an edge):
  - DATA_OUT=0, SEL=1, WR=0, ERR=0, DONE=0.
  - Pointer = A, FSM = IDLE, counter = 0, both synchronizer flops = 1.
  - Reset overrides every other input, including mid-debounce and mid-hold; a press in progress is discarded.
- Synchronizer: two flops on KEYn; the FSM uses only the second-stage value, called k.
- FSM states:
  - IDLE: k=0 -> PRESS_DB with cnt=1.
  - PRESS_DB:
    - k=1 -> IDLE, cnt=0.
    - k=0 and cnt==DEBOUNCE_CYCLES-1 -> HELD; the accept event fires on this edge.
    - Otherwise cnt+1.
  - HELD: k=1 -> REL_DB with cnt=1; no output activity.
  - REL_DB:
    - k=0 -> HELD, with no new accept.
    - k=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0.
    - Otherwise cnt+1.
- Latency: if stage 1 first samples KEYn low at edge e0 and KEYn stays low, the accept edge is e0+DEBOUNCE_CYCLES+1.
- Accept event, BCD<=9:
  - Register DATA_OUT=BCD and SEL=pointer, and pulse WR high for exactly one cycle.
  - If the pointer was B, also pulse DONE.
  - Toggle the pointer.
- Accept event, BCD>9: pulse ERR for one cycle. WR, DONE, DATA_OUT, SEL and the pointer are unchanged.
- Between writes:
  - WR, ERR and DONE are 0 in every cycle other than an accept cycle.
  - DATA_OUT and SEL hold their values, so the downstream stage may capture on WR.
- CLR=1 at an edge:
  - Pointer = A and SEL=1; DATA_OUT is unchanged; FSM and counter are unaffected.
  - If CLR coincides with an accept, CLR wins: no WR, ERR or DONE, and the pointer is A afterwards. The press is consumed (FSM still enters HELD).
- Holding the key generates no repeat writes; a new press requires a full release debounce back to IDLE.
- Bounces shorter than DEBOUNCE_CYCLES samples on either edge produce no output.
- The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around occurs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then KEYn low from edge e0 with BCD=7 -> WR=1 only after edge e0+5; DATA_OUT=7, SEL=1, DONE=0; after that, SEL=1 is held and WR=0.
- Release fully, then press with BCD=3 -> WR pulse with DATA_OUT=3, SEL=0, DONE=1; a third press with BCD=5 -> SEL=1, DATA_OUT=5.
- KEYn glitches low for 3 synchronized samples, then high -> no WR/ERR, FSM back in IDLE; a glitch high for 2 samples during hold -> no second WR.
- Press with BCD=4'hB -> ERR pulse for one cycle, WR=0, DATA_OUT/SEL unchanged; the next valid press still targets the same digit.
- Write digit A (BCD=2), then CLR pulse, then press with BCD=9 -> SEL=1, DATA_OUT=9, DONE=0; CLR asserted on the accept edge -> no WR, pointer stays A.
- RESETn low for 1 cycle mid-PRESS_DB, and separately mid-HELD -> all outputs return to reset values; the held key produces no write until released and pressed again.

Source files
------------

// File: rtl/bcd_entry_sequencer.sv
// Debounced pushbutton entry of two BCD digits (tens then ones) into a
// dual 7-segment memory stage; one write strobe per accepted press.
module bcd_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       KEYn,
    input  logic [3:0] BCD,
    input  logic       CLR,
    output logic [3:0] DATA_OUT,
    output logic       SEL,
    output logic       WR,
    output logic       ERR,
    output logic       DONE
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESS_DB = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_REL_DB   = 2'd3;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ptr_a;
    logic [3:0]       r_data;
    logic             r_sel;
    logic             r_wr;
    logic             r_err;
    logic             r_done;

    logic w_k;
    logic w_last;
    logic w_accept;
    logic w_valid;

    assign w_k      = r_sync2;
    assign w_last   = (r_cnt == LP_LAST);
    assign w_accept = (r_state == S_PRESS_DB) && !w_k && w_last;
    assign w_valid  = (BCD <= 4'd9);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEYn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_k) begin
                        r_state <= S_PRESS_DB;
                        r_cnt   <= LP_ONE;
                    end
                end
                S_PRESS_DB: begin
                    if (w_k) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                S_HELD: begin
                    if (w_k) begin
                        r_state <= S_REL_DB;
                        r_cnt   <= LP_ONE;
                    end
                end
                default: begin
                    if (!w_k) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
            endcase
        end
    end

    // CLR takes priority over a coincident accept; the press is still consumed
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_ptr_a <= 1'b1;
            r_data  <= 4'd0;
            r_sel   <= 1'b1;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            if (CLR) begin
                r_ptr_a <= 1'b1;
                r_sel   <= 1'b1;
            end else if (w_accept) begin
                if (w_valid) begin
                    r_data  <= BCD;
                    r_sel   <= r_ptr_a;
                    r_wr    <= 1'b1;
                    r_done  <= !r_ptr_a;
                    r_ptr_a <= !r_ptr_a;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign DATA_OUT = r_data;
    assign SEL      = r_sel;
    assign WR       = r_wr;
    assign ERR      = r_err;
    assign DONE     = r_done;

endmodule

// File: tb/tb_bcd_entry_sequencer.sv
// Directed bench for bcd_entry_sequencer with a write/error event scoreboard.
module tb_bcd_entry_sequencer;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       KEYn;
    logic [3:0] BCD;
    logic       CLR;
    logic [3:0] DATA_OUT;
    logic       SEL;
    logic       WR;
    logic       ERR;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    // entry: {1'b0, err, done, wr, sel, data[3:0]}
    logic [7:0] sb_q[$];

    logic [3:0] m_data;
    logic       m_sel;
    logic       m_ptr;

    bcd_entry_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .KEYn(KEYn),
        .BCD(BCD),
        .CLR(CLR),
        .DATA_OUT(DATA_OUT),
        .SEL(SEL),
        .WR(WR),
        .ERR(ERR),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_data = 4'd0;
        m_sel  = 1'b1;
        m_ptr  = 1'b1;
    endtask

    task automatic model_clr();
        m_ptr = 1'b1;
        m_sel = 1'b1;
    endtask

    task automatic push_exp(input logic [3:0] bcd);
        if (bcd <= 4'd9) begin
            sb_q.push_back({1'b0, 1'b0, !m_ptr, 1'b1, m_ptr, bcd});
            m_data = bcd;
            m_sel  = m_ptr;
            m_ptr  = !m_ptr;
        end else begin
            sb_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, m_sel, m_data});
        end
    endtask

    task automatic press(input logic [3:0] bcd);
        BCD = bcd;
        push_exp(bcd);
        KEYn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic release_key();
        KEYn = 1'b1;
        repeat (10) tick();
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_data"}, {4'd0, DATA_OUT}, {4'd0, m_data});
        chk({tag, "_sel"}, {7'd0, SEL}, {7'd0, m_sel});
        chk({tag, "_strobes"}, {5'd0, WR, ERR, DONE}, 8'd0);
    endtask

    always @(negedge CLK) begin
        if (RESETn === 1'b1 && (WR !== 1'b0 || ERR !== 1'b0)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {3'd0, ERR, DONE, WR, SEL, 1'b0}, 8'd0);
            end else begin
                chk("event", {1'b0, ERR, DONE, WR, SEL, DATA_OUT},
                    sb_q.pop_front());
            end
        end
    end

    initial begin
        RESETn = 1'b0;
        KEYn   = 1'b1;
        BCD    = 4'd0;
        CLR    = 1'b0;
        model_reset();
        tick();
        tick();
        RESETn = 1'b1;
        tick();
        chk_outs("reset");

        // first press: exact accept latency
        BCD = 4'd7;
        push_exp(4'd7);
        KEYn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wr_early", {7'd0, WR}, 8'd0);
        end
        tick();
        chk("wr_accept", {7'd0, WR}, 8'd1);
        chk("data_7", {4'd0, DATA_OUT}, 8'd7);
        chk("sel_a", {7'd0, SEL}, 8'd1);
        chk("done_a", {7'd0, DONE}, 8'd0);
        tick();
        chk("wr_after", {7'd0, WR}, 8'd0);
        chk("sel_hold", {7'd0, SEL}, 8'd1);
        repeat (8) tick();
        chk_outs("held_no_repeat");
        release_key();

        press(4'd3);
        chk_outs("digit_b");
        release_key();
        press(4'd5);
        chk_outs("third");
        release_key();

        // short low glitch: 3 synchronized samples
        KEYn = 1'b0;
        repeat (3) tick();
        KEYn = 1'b1;
        repeat (10) tick();
        chk_outs("glitch_low");

        press(4'd6);
        // short high glitch while held
        KEYn = 1'b1;
        repeat (2) tick();
        KEYn = 1'b0;
        repeat (10) tick();
        chk_outs("glitch_high");
        release_key();

        press(4'hB);
        chk_outs("err_hold");
        release_key();
        press(4'd1);
        chk_outs("after_err");
        release_key();

        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        model_clr();
        chk_outs("clr0");
        press(4'd2);
        release_key();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        model_clr();
        chk_outs("clr1");
        press(4'd9);
        chk_outs("after_clr");
        release_key();

        // CLR coincident with the accept edge
        BCD  = 4'd4;
        KEYn = 1'b0;
        repeat (5) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        model_clr();
        chk_outs("clr_accept");
        repeat (6) tick();
        chk_outs("clr_accept_held");
        release_key();
        press(4'd4);
        chk_outs("ptr_a_after_clr");
        release_key();

        // reset in the middle of press debounce
        BCD  = 4'd5;
        KEYn = 1'b0;
        repeat (4) tick();
        RESETn = 1'b0;
        KEYn   = 1'b1;
        tick();
        RESETn = 1'b1;
        model_reset();
        chk_outs("rst_press_db");
        repeat (10) tick();
        chk_outs("rst_press_db_idle");

        press(4'd8);
        RESETn = 1'b0;
        KEYn   = 1'b1;
        tick();
        RESETn = 1'b1;
        model_reset();
        chk_outs("rst_held");
        repeat (10) tick();
        chk_outs("rst_held_idle");
        press(4'd3);
        chk_outs("after_rst");
        release_key();

        chk("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
